// File: rtl/rom_sequencer.sv
// Fetch/execute controller for a 4-entry, 2-bit opcode ROM. It addresses the ROM,
// latches each opcode, executes it against an accumulator and stops on HLT or on an illegal opcode.
module rom_sequencer #(
  parameter int         ACC_WIDTH  = 4,
  parameter logic [1:0] JNO_TARGET = 2'd0,
  parameter int         CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           instr,
  output logic                 sel1,
  output logic                 sel2,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 ovf,
  output logic                 busy,
  output logic                 halted,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] retired
);

  // state | meaning
  // IDLE  | out of reset, waiting for start
  // FETCH | ROM addressed by pc, opcode latched into ir
  // EXEC  | ir decoded and executed, retired counter advanced
  // HALT  | stopped on HLT or illegal opcode, waiting for start
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_JNO = 2'b01;
  localparam logic [1:0] OP_HLT = 2'b10;

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           pc;
  logic [1:0]           ir;
  logic [ACC_WIDTH:0]   acc_inc;
  logic [CNT_WIDTH-1:0] retired_inc;
  logic                 launch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_nxt = FETCH;
          launch    = 1'b1;
        end
      end
      FETCH: state_nxt = EXEC;
      EXEC: begin
        if (ir == OP_INC || ir == OP_JNO) state_nxt = FETCH;
        else                              state_nxt = HALT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign acc_inc     = {1'b0, acc} + {{ACC_WIDTH{1'b0}}, 1'b1};
  assign retired_inc = (&retired) ? retired : retired + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= 2'd0;
      ir      <= 2'b00;
      acc     <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
      retired <= '0;
    end else if (launch) begin
      pc      <= 2'd0;
      acc     <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
      retired <= '0;
    end else if (state == FETCH) begin
      ir <= instr;
    end else if (state == EXEC) begin
      retired <= retired_inc;
      case (ir)
        OP_INC: begin
          {ovf, acc} <= acc_inc;
          pc         <= pc + 2'd1;
        end
        OP_JNO: begin
          // Loop back while the accumulator has not wrapped yet.
          if (!ovf) pc <= JNO_TARGET;
          else      pc <= pc + 2'd1;
        end
        OP_HLT: ;
        default: err <= 1'b1;
      endcase
    end
  end

  // ROM select comes straight from the pc flops so instr is stable across FETCH.
  assign sel1   = pc[0];
  assign sel2   = pc[1];
  assign busy   = (state == FETCH) || (state == EXEC);
  assign halted = (state == HALT);

endmodule
